design_27_initiator: RTL and testbench

Transaction initiator for the design_27 start/valid compute interface. It accepts operand pairs from a host over a ready/valid request channel and drives `start`, `a` and `b` into the compute block. It waits for the block's `valid`, captures `y`, and returns the result (or a timeout error) over a ready/valid response channel. It sits between the host/test sequencer and the design_27 instance; only one transaction is outstanding at a time.

---
 rtl/design_27_initiator.sv | 110 +++++++++++
 tb/tb_design_27_initiator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/design_27_initiator.sv
// Start/valid transaction initiator: one outstanding operand pair, result or timeout returned over ready/valid.
// dut_start fires 1 cycle after acceptance; response 1 cycle after dut_valid; req_ready only in IDLE.
module design_27_initiator #(
  parameter int W       = 12,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_err,
  output logic         dut_start,
  output logic [W-1:0] dut_a,
  output logic [W-1:0] dut_b,
  input  logic [W-1:0] dut_y,
  input  logic         dut_valid,
  output logic         busy,
  output logic [7:0]   stray_cnt
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     stray_q, stray_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      stray_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stray_d = stray_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving on the last wait cycle still beats the timeout.
        if (dut_valid) begin
          y_d     = dut_y;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (dut_valid && state_q != WAIT && stray_q != 8'hFF)
      stray_d = stray_q + 8'd1;
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign dut_start = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_y     = y_q;
  assign rsp_err   = err_q;
  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign stray_cnt = stray_q;

endmodule

// File: tb/tb_design_27_initiator.sv
// Bench for design_27_initiator: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-timing model.
module tb_design_27_initiator;
  localparam int W  = 12;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic         dut_start, dut_valid, busy;
  logic [W-1:0] req_a, req_b, rsp_y, dut_a, dut_b, dut_y;
  logic [7:0]   stray_cnt;

  design_27_initiator #(.W(W), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .dut_start(dut_start), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .dut_valid(dut_valid), .busy(busy), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is described by the number of edges since it was accepted.
  // Edge 1 closes the start cycle; edges 2..TO+1 are the window in which a result counts;
  // without one the response is an error after edge TO+1.
  logic         m_busy, m_resp, m_err;
  int           m_k;
  logic [W-1:0] m_a, m_b, m_y;
  int           m_stray;

  task automatic bump_stray();
    if (m_stray < 255) m_stray++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_resp = 1'b0; m_err = 1'b0; m_k = 0;
      m_a = '0; m_b = '0; m_y = '0; m_stray = 0;
    end else if (!m_busy) begin
      if (dut_valid) bump_stray();
      if (req_valid) begin
        m_busy = 1'b1; m_k = 0; m_a = req_a; m_b = req_b;
      end
    end else if (m_resp) begin
      if (dut_valid) bump_stray();
      if (rsp_ready) begin
        m_busy = 1'b0; m_resp = 1'b0;
      end
    end else begin
      m_k++;
      if (m_k == 1) begin
        if (dut_valid) bump_stray();
      end else if (dut_valid) begin
        m_resp = 1'b1; m_y = dut_y; m_err = 1'b0;
      end else if (m_k == TO + 1) begin
        m_resp = 1'b1; m_y = '0; m_err = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
      chk("m_busy",      32'(busy),      32'(m_busy));
      chk("m_start",     32'(dut_start), 32'(m_busy && !m_resp && m_k == 0));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("m_rsp_y",     32'(rsp_y),     32'(m_y));
      chk("m_rsp_err",   32'(rsp_err),   32'(m_err));
      chk("m_dut_a",     32'(dut_a),     32'(m_a));
      chk("m_dut_b",     32'(dut_b),     32'(m_b));
      chk("m_stray",     32'(stray_cnt), 32'(m_stray));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_y"},     32'(rsp_y),     32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_start"},     32'(dut_start), 32'd0);
    chk({tag, "_dut_a"},     32'(dut_a),     32'd0);
    chk({tag, "_dut_b"},     32'(dut_b),     32'd0);
    chk({tag, "_stray"},     32'(stray_cnt), 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int            n;
  logic [W-1:0]  held_y;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; dut_valid = 1'b0; dut_y = '0;
    #12;
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Basic transaction: result 3 cycles after start.
    issue(12'h123, 12'h456);
    chk("basic_start", 32'(dut_start), 32'd1);
    chk("basic_a", 32'(dut_a), 32'h123);
    chk("basic_b", 32'(dut_b), 32'h456);
    tick();
    chk("basic_start_once", 32'(dut_start), 32'd0);
    tick();
    tick();
    dut_valid = 1'b1; dut_y = 12'h579;
    chk("basic_no_early_rsp", 32'(rsp_valid), 32'd0);
    tick();
    dut_valid = 1'b0;
    chk("basic_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("basic_rsp_y", 32'(rsp_y), 32'h579);
    chk("basic_rsp_err", 32'(rsp_err), 32'd0);
    release_rsp();
    chk("basic_ready_back", 32'(req_ready), 32'd1);

    // Timeout: no result ever arrives.
    issue(12'h0AA, 12'h055);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TO + 1));
    chk("timeout_err", 32'(rsp_err), 32'd1);
    chk("timeout_y", 32'(rsp_y), 32'd0);
    release_rsp();

    // Boundary: result on the last wait cycle wins over timeout.
    issue(12'h111, 12'h222);
    repeat (TO) tick();
    dut_valid = 1'b1; dut_y = 12'hABC;
    tick();
    dut_valid = 1'b0;
    chk("bound_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bound_err", 32'(rsp_err), 32'd0);
    chk("bound_y", 32'(rsp_y), 32'hABC);
    release_rsp();

    // Backpressure with a stray valid and a request held during busy.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    issue(12'h321, 12'h654);
    tick();
    dut_valid = 1'b1; dut_y = 12'h5A5;
    tick();
    dut_valid = 1'b0;
    held_y = rsp_y;
    chk("bp_y", 32'(held_y), 32'h5A5);
    req_valid = 1'b1; req_a = 12'hF0F; req_b = 12'h0F0;
    for (int i = 0; i < 10; i++) begin
      dut_valid = (i == 4);
      dut_y = 12'hEEE;
      tick();
      chk("bp_hold_y", 32'(rsp_y), 32'(held_y));
      chk("bp_hold_err", 32'(rsp_err), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      chk("bp_dut_a_held", 32'(dut_a), 32'h321);
    end
    dut_valid = 1'b0;
    chk("bp_stray", 32'(stray_cnt), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_ready_after", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_next_a", 32'(dut_a), 32'hF0F);
    chk("bp_next_start", 32'(dut_start), 32'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_next_done", 32'(rsp_valid), 32'd1);
    release_rsp();

    // Reset during WAIT, then a normal transaction.
    issue(12'h777, 12'h888);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    issue(12'h100, 12'h200);
    tick();
    dut_valid = 1'b1; dut_y = 12'h300;
    tick();
    dut_valid = 1'b0;
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_y", 32'(rsp_y), 32'h300);
    chk("post_rst_err", 32'(rsp_err), 32'd0);
    release_rsp();

    // Saturation of the stray counter.
    dut_valid = 1'b1;
    repeat (300) tick();
    dut_valid = 1'b0;
    chk("stray_sat", 32'(stray_cnt), 32'd255);

    // Randomized traffic checked by the model on every cycle.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_a     = W'($urandom);
      req_b     = W'($urandom);
      dut_valid = ($urandom_range(0, 5) == 0);
      dut_y     = W'($urandom);
      rsp_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    req_valid = 1'b0; dut_valid = 1'b0; rsp_ready = 1'b1;
    repeat (TO + 4) tick();
    chk("drain_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
